// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the lsu_stage load/store pipeline stage.
//   - default widths and the rd field position inside an instruction
//   - sb_entry_t, the {addr, data} pair held by a store buffer entry
//   - LSU_OP_* encodings of the {isld, isst, iswb} flag triple
//   - rd_of(): rd field extraction for the default instruction layout
package lsu_pkg;

  localparam int LSU_DATA_W  = 16;
  localparam int LSU_INSTR_W = 16;
  localparam int LSU_ADDR_W  = 8;
  localparam int LSU_RD_W    = 4;
  localparam int LSU_RD_LSB  = 8;
  localparam int LSU_SB_DEPTH = 4;

  typedef struct packed {
    logic [LSU_ADDR_W-1:0] addr;
    logic [LSU_DATA_W-1:0] data;
  } sb_entry_t;

  // Flag triple ordering is {isld, isst, iswb}.
  localparam logic [2:0] LSU_OP_NOP = 3'b000;
  localparam logic [2:0] LSU_OP_ALU = 3'b001;
  localparam logic [2:0] LSU_OP_ST  = 3'b010;
  localparam logic [2:0] LSU_OP_LD  = 3'b101;

  function automatic logic [LSU_RD_W-1:0] rd_of(input logic [LSU_INSTR_W-1:0] instr);
    return instr[LSU_RD_LSB +: LSU_RD_W];
  endfunction

endpackage

// File: rtl/lsu_store_buffer.sv
// lsu_store_buffer: FIFO of posted stores with an address-match view.
// Optional feature macro: LSU_STORE_FWD_EN
//   defined   -> match_data returns the youngest matching entry's data
//   undefined -> only match_any is produced, match_data is 0
// Ports:
//   clk, reset          clock, asynchronous active-low reset (empties buffer)
//   push/push_addr/push_data  enqueue at tail (caller guarantees !full)
//   pop                 dequeue head (caller guarantees !empty)
//   full, empty         occupancy flags
//   head_addr/head_data oldest entry, written to memory on pop
//   match_addr          address compared against every valid entry
//   match_any           some valid entry holds match_addr
//   match_data          youngest matching entry's data (forwarding build)
module lsu_store_buffer #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W-1:0] head_addr,
  output logic [DATA_W-1:0] head_data,
  input  logic [ADDR_W-1:0] match_addr,
  output logic              match_any,
  output logic [DATA_W-1:0] match_data
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  // One extra bit so that DEPTH entries is distinct from zero.
  logic [PTR_W:0]    count;
  logic [DEPTH-1:0]  ent_valid;

  assign full      = (count == FULL_CNT);
  assign empty     = (count == '0);
  assign head_addr = addr_q[head];
  assign head_data = data_q[head];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // Entry storage is not reset; ent_valid decides what is meaningful.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail] <= push_addr;
      data_q[tail] <= push_data;
    end
  end

  // A physical slot is valid when its distance from head is below count.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_valid[i] = ({1'b0, PTR_W'(i) - head} < count);
    end
  end

`ifdef LSU_STORE_FWD_EN
  logic [PTR_W-1:0] idx;

  // Walk oldest to youngest; the last hit overwrites, so the youngest wins.
  always_comb begin
    match_any  = 1'b0;
    match_data = '0;
    idx        = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PTR_W'(k);
      if (ent_valid[idx] && (addr_q[idx] == match_addr)) begin
        match_any  = 1'b1;
        match_data = data_q[idx];
      end
    end
  end
`else
  always_comb begin
    match_any = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_valid[i] && (addr_q[i] == match_addr)) match_any = 1'b1;
    end
  end

  assign match_data = '0;
`endif

endmodule

// File: rtl/lsu_stage.sv
// lsu_stage: load/store pipeline stage between execute and writeback with a
// private word-addressed data memory and a posted-store FIFO.
// Optional feature macro: LSU_STORE_FWD_EN (store-to-load forwarding).
// Ports:
//   clk, reset            clock, asynchronous active-low reset
//   in_valid              operation presented this cycle
//   isld, isst, iswb      load / store / writeback flags (isst wins over isld)
//   instr, op2, aluresult instruction, store data, address-or-result
//   stall                 combinational push-back to execute
//   out_valid             registered outputs hold a retired operation
//   aluresult_out, isld_out, iswb_out, instr_out  registered pass-through
//   ldresult              load data (0 for non-loads)
//   rdvalmem              {rd, ldresult or aluresult_out}
//   sb_empty              store buffer holds no entries
module lsu_stage
  import lsu_pkg::*;
#(
  parameter int DATA_W   = LSU_DATA_W,
  parameter int INSTR_W  = LSU_INSTR_W,
  parameter int ADDR_W   = LSU_ADDR_W,
  parameter int RD_W     = LSU_RD_W,
  parameter int RD_LSB   = LSU_RD_LSB,
  parameter int SB_DEPTH = LSU_SB_DEPTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic                   isld,
  input  logic                   isst,
  input  logic                   iswb,
  input  logic [INSTR_W-1:0]     instr,
  input  logic [DATA_W-1:0]      op2,
  input  logic [DATA_W-1:0]      aluresult,
  output logic                   stall,
  output logic                   out_valid,
  output logic [DATA_W-1:0]      aluresult_out,
  output logic                   isld_out,
  output logic                   iswb_out,
  output logic [INSTR_W-1:0]     instr_out,
  output logic [DATA_W-1:0]      ldresult,
  output logic [RD_W+DATA_W-1:0] rdvalmem,
  output logic                   sb_empty
);

  // Handshake: an operation transfers on a rising edge where in_valid is high
  // and stall is low. While stall is high, execute must hold every input
  // stable; stall never depends on anything but current inputs and state.

  logic [ADDR_W-1:0] addr;
  logic              is_ld;
  logic              is_st;
  logic              accept;
  logic              ld_block;
  logic              sb_push;
  logic              sb_pop;
  logic              sb_full;
  logic              sb_is_empty;
  logic              sb_match;
  logic [ADDR_W-1:0] sb_head_addr;
  logic [DATA_W-1:0] sb_head_data;
  logic [DATA_W-1:0] sb_match_data;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] load_data;

  logic [DATA_W-1:0] mem [2**ADDR_W];

  assign addr  = aluresult[ADDR_W-1:0];
  assign is_st = isst;
  assign is_ld = isld & ~isst;

`ifdef LSU_STORE_FWD_EN
  assign ld_block = 1'b0;
`else
  // Without forwarding a load must wait until every matching store drained.
  assign ld_block = sb_match;
`endif

  assign stall  = in_valid & ((is_st & sb_full) | (is_ld & ld_block));
  assign accept = in_valid & ~stall;

  assign sb_push = accept & is_st;
  // Memory port is free whenever no load or store was accepted, including
  // the stall cycles, which is what lets a full or blocking buffer make room.
  assign sb_pop  = ~sb_is_empty & ~(accept & (is_ld | is_st));

  lsu_store_buffer #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (SB_DEPTH)
  ) u_sb (
    .clk        (clk),
    .reset      (reset),
    .push       (sb_push),
    .push_addr  (addr),
    .push_data  (op2),
    .pop        (sb_pop),
    .full       (sb_full),
    .empty      (sb_is_empty),
    .head_addr  (sb_head_addr),
    .head_data  (sb_head_data),
    .match_addr (addr),
    .match_any  (sb_match),
    .match_data (sb_match_data)
  );

  // Data memory: not reset, written only by draining the buffer head.
  always_ff @(posedge clk) begin
    if (sb_pop) mem[sb_head_addr] <= sb_head_data;
  end

  assign mem_rdata = mem[addr];
  // An accepted load only sees sb_match when forwarding is built in.
  assign load_data = sb_match ? sb_match_data : mem_rdata;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid     <= 1'b0;
      aluresult_out <= '0;
      isld_out      <= 1'b0;
      iswb_out      <= 1'b0;
      instr_out     <= '0;
      ldresult      <= '0;
    end else begin
      out_valid <= accept;
      if (accept) begin
        aluresult_out <= aluresult;
        isld_out      <= is_ld;
        iswb_out      <= iswb;
        instr_out     <= instr;
        ldresult      <= is_ld ? load_data : '0;
      end
    end
  end

  assign rdvalmem = {instr_out[RD_LSB +: RD_W], (isld_out ? ldresult : aluresult_out)};
  assign sb_empty = sb_is_empty;

endmodule

// File: tb/tb_lsu_stage.sv
// tb_lsu_stage: directed self-checking bench for lsu_stage (default widths).
// Honours LSU_STORE_FWD_EN for the expected stall counts of blocked loads.
module tb_lsu_stage;
  import lsu_pkg::*;

`ifdef LSU_STORE_FWD_EN
  localparam int FWD = 1;
`else
  localparam int FWD = 0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        isld;
  logic        isst;
  logic        iswb;
  logic [15:0] instr;
  logic [15:0] op2;
  logic [15:0] aluresult;
  logic        stall;
  logic        out_valid;
  logic [15:0] aluresult_out;
  logic        isld_out;
  logic        iswb_out;
  logic [15:0] instr_out;
  logic [15:0] ldresult;
  logic [19:0] rdvalmem;
  logic        sb_empty;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  int s;

  lsu_stage dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .isld          (isld),
    .isst          (isst),
    .iswb          (iswb),
    .instr         (instr),
    .op2           (op2),
    .aluresult     (aluresult),
    .stall         (stall),
    .out_valid     (out_valid),
    .aluresult_out (aluresult_out),
    .isld_out      (isld_out),
    .iswb_out      (iswb_out),
    .instr_out     (instr_out),
    .ldresult      (ldresult),
    .rdvalmem      (rdvalmem),
    .sb_empty      (sb_empty)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Driver: present an op, wait out any stall (bounded), return after the
  // accepting edge with outputs settled. stalls = cycles spent stalled.
  task automatic drive_op(input logic [2:0] op, input logic [15:0] alu,
                          input logic [15:0] data, input logic [15:0] ins,
                          output int stalls);
    {isld, isst, iswb} = op;
    aluresult = alu;
    op2       = data;
    instr     = ins;
    in_valid  = 1'b1;
    stalls    = 0;
    #1;
    while (stall && stalls < 16) begin
      @(posedge clk); #1;
      stalls++;
    end
    if (stall) check("stall_bound", 32'(stall), 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    {isld, isst, iswb} = LSU_OP_NOP;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    // Reset with random inputs
    reset     = 1'b0;
    in_valid  = 1'($urandom_range(0, 1));
    {isld, isst, iswb} = 3'($urandom_range(0, 7));
    instr     = 16'($urandom_range(0, 65535));
    op2       = 16'($urandom_range(0, 65535));
    aluresult = 16'($urandom_range(0, 65535));
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_aluresult_out", 32'(aluresult_out), 32'd0);
    check("rst_isld_out", 32'(isld_out), 32'd0);
    check("rst_iswb_out", 32'(iswb_out), 32'd0);
    check("rst_instr_out", 32'(instr_out), 32'd0);
    check("rst_ldresult", 32'(ldresult), 32'd0);
    check("rst_rdvalmem", 32'(rdvalmem), 32'd0);
    check("rst_sb_empty", 32'(sb_empty), 32'd1);

    reset    = 1'b1;
    in_valid = 1'b0;
    {isld, isst, iswb} = LSU_OP_NOP;
    #1;
    check("post_rst_stall", 32'(stall), 32'd0);

    // Pass-through ALU op, rd=3
    drive_op(LSU_OP_ALU, 16'h1234, 16'h0, 16'h0300, s);
    check("alu_stalls", 32'(s), 32'd0);
    check("alu_out_valid", 32'(out_valid), 32'd1);
    check("alu_rdvalmem", 32'(rdvalmem), 32'h31234);
    check("alu_ldresult", 32'(ldresult), 32'd0);
    check("alu_iswb_out", 32'(iswb_out), 32'd1);
    check("alu_isld_out", 32'(isld_out), 32'd0);
    idle(1);
    check("idle_out_valid", 32'(out_valid), 32'd0);

    // Store then load back-to-back, addr 4
    drive_op(LSU_OP_ST, 16'h0004, 16'hA505, 16'h0, s);
    check("st4_stalls", 32'(s), 32'd0);
    check("st4_sb_empty", 32'(sb_empty), 32'd0);
    drive_op(LSU_OP_LD, 16'h0004, 16'h0, 16'h0500, s);
    check("ld4_stalls", 32'(s), FWD ? 32'd0 : 32'd1);
    check("ld4_ldresult", 32'(ldresult), 32'hA505);
    check("ld4_rdvalmem", 32'(rdvalmem), 32'h5A505);
    check("ld4_isld_out", 32'(isld_out), 32'd1);
    idle(4);
    check("ld4_drained", 32'(sb_empty), 32'd1);

    // Two stores to one address: the younger one must be observed
    drive_op(LSU_OP_ST, 16'h0007, 16'h1111, 16'h0, s);
    drive_op(LSU_OP_ST, 16'h0007, 16'h2222, 16'h0, s);
    drive_op(LSU_OP_LD, 16'h0007, 16'h0, 16'h0200, s);
    check("young_stalls", 32'(s), FWD ? 32'd0 : 32'd2);
    check("young_ldresult", 32'(ldresult), 32'h2222);
    idle(4);

    // Buffer full: five stores, only the fifth stalls for one cycle
    for (int i = 0; i < 5; i++) begin
      drive_op(LSU_OP_ST, 16'(i), 16'h1000 + 16'(i), 16'h0, s);
      check($sformatf("full_st%0d_stalls", i), 32'(s), 32'(i == 4));
    end
    check("full_sb_nonempty", 32'(sb_empty), 32'd0);
    idle(6);
    check("full_sb_empty", 32'(sb_empty), 32'd1);
    for (int i = 0; i < 5; i++) begin
      drive_op(LSU_OP_LD, 16'(i), 16'h0, 16'h0100, s);
      check($sformatf("full_ld%0d", i), 32'(ldresult), 32'h1000 + 32'(i));
    end

    // Address wrap: upper address bits are ignored
    drive_op(LSU_OP_ST, 16'h0104, 16'hBEEF, 16'h0, s);
    idle(3);
    drive_op(LSU_OP_LD, 16'h0004, 16'h0, 16'h0100, s);
    check("wrap_ldresult", 32'(ldresult), 32'hBEEF);
    idle(2);

    // Reset with three stores pending: they must be discarded
    for (int i = 0; i < 3; i++) begin
      drive_op(LSU_OP_ST, 16'(i), 16'hD000 + 16'(i), 16'h0, s);
    end
    check("mid_sb_pending", 32'(sb_empty), 32'd0);
    reset = 1'b0;
    #1;
    check("mid_rst_sb_empty", 32'(sb_empty), 32'd1);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    idle(2);
    for (int i = 0; i < 3; i++) begin
      drive_op(LSU_OP_LD, 16'(i), 16'h0, 16'h0100, s);
      check($sformatf("mid_ld%0d", i), 32'(ldresult), 32'h1000 + 32'(i));
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
